// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation pipeline sequencer: scan FSM
// states, default datapath widths and the quadrant grid size.
package interp_pkg;

  localparam int W_DIM     = 8;
  localparam int W_ADDR    = 16;
  // The image is split into a 2^GRID_LOG2 x 2^GRID_LOG2 grid of quadrants.
  localparam int GRID_LOG2 = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } scan_state_t;

endpackage

// File: rtl/quad_addr_gen.sv
// Row-major address walker for one quadrant. Holds the current x/y position,
// the scan bounds and the running row base (y*W), which is accumulated by
// adding the image width once per row so the scan needs no multiplier.
module quad_addr_gen #(
  parameter int W_DIM  = 8,
  parameter int W_ADDR = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [W_DIM-1:0]  start_x,
  input  logic [W_DIM-1:0]  end_x,
  input  logic [W_DIM-1:0]  start_y,
  input  logic [W_DIM-1:0]  end_y,
  input  logic [W_DIM-1:0]  width,
  input  logic [W_ADDR-1:0] row_base_init,
  output logic [W_ADDR-1:0] addr,
  output logic              last
);

  localparam logic [W_DIM-1:0]  ONE_DIM  = 1;
  localparam logic [W_ADDR-1:0] ONE_ADDR = 1;

  logic [W_DIM-1:0]  x_q, x_d, y_q, y_d;
  logic [W_DIM-1:0]  bx_q, bx_d, ex_q, ex_d, ey_q, ey_d;
  logic [W_ADDR-1:0] row_q, row_d, addr_q, addr_d;

  // Next position: load the quadrant origin, or step x and wrap to the next row.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    bx_d   = bx_q;
    ex_d   = ex_q;
    ey_d   = ey_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (load) begin
      bx_d   = start_x;
      ex_d   = end_x;
      ey_d   = end_y;
      x_d    = start_x;
      y_d    = start_y;
      row_d  = row_base_init;
      addr_d = row_base_init + W_ADDR'(start_x);
    end else if (advance) begin
      if (x_q == ex_q) begin
        x_d    = bx_q;
        y_d    = y_q + ONE_DIM;
        row_d  = row_q + W_ADDR'(width);
        addr_d = row_q + W_ADDR'(width) + W_ADDR'(bx_q);
      end else begin
        x_d    = x_q + ONE_DIM;
        addr_d = addr_q + ONE_ADDR;
      end
    end
  end

  // Position and bound registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      bx_q   <= '0;
      ex_q   <= '0;
      ey_q   <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      bx_q   <= bx_d;
      ex_q   <= ex_d;
      ey_q   <= ey_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (x_q == ex_q) && (y_q == ey_q);

endmodule

// File: rtl/quad_scan_ctrl.sv
// Quadrant scan sequencer: latches a quadrant index and image size, issues
// the quadrant's source addresses over valid/ready, counts written-back
// results and pulses done (or err for a degenerate quadrant).
// Build option: QUAD_BORDER_EN widens the scan by one pixel right and down
// (clamped to the image) so bilinear neighbours are fetched too.
module quad_scan_ctrl #(
  parameter int W_DIM  = interp_pkg::W_DIM,
  parameter int W_ADDR = interp_pkg::W_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        cuadrante,
  input  logic [15:0]       dimensiones,
  output logic [W_ADDR-1:0] src_addr,
  output logic              src_valid,
  input  logic              src_ready,
  input  logic              res_valid,
  output logic [W_DIM-1:0]  quad_w,
  output logic [W_DIM-1:0]  quad_h,
  output logic              busy,
  output logic              done,
  output logic              err
);

  import interp_pkg::*;

  localparam logic [W_DIM-1:0]  ONE_DIM  = 1;
  localparam logic [W_ADDR-1:0] ONE_ADDR = 1;

  // Quadrant origin along one axis: idx (0..3) times the quadrant size,
  // built from a shift and an add since idx is only two bits.
  function automatic logic [W_DIM-1:0] grid_mul(input logic [1:0] idx,
                                                input logic [W_DIM-1:0] step);
    grid_mul = (idx[1] ? (step << 1) : '0) + (idx[0] ? step : '0);
  endfunction

  scan_state_t       state_q, state_d;
  logic [3:0]        cuad_q, cuad_d;
  logic [W_DIM-1:0]  w_q, w_d, h_q, h_d;
  logic [W_DIM-1:0]  quad_w_q, quad_w_d, quad_h_q, quad_h_d;
  logic [W_ADDR-1:0] iss_cnt_q, iss_cnt_d, res_cnt_q, res_cnt_d;

  logic [W_DIM-1:0]  qw, qh, bx, by, ex, ey, ext_w, ext_h;
  logic [W_ADDR-1:0] row_base;
  logic              geom_bad;
  logic              handshake;
  logic              gen_load, gen_advance, gen_last;
  logic [W_ADDR-1:0] gen_addr;

  // Quadrant geometry from the latched job parameters; consumed in INIT.
  always_comb begin
    qw = w_q >> GRID_LOG2;
    qh = h_q >> GRID_LOG2;
    bx = grid_mul(cuad_q[1:0], qw);
    by = grid_mul(cuad_q[3:2], qh);
`ifdef QUAD_BORDER_EN
    // bx+qw never exceeds W, so the sum fits and only W itself needs clamping.
    ex = ((bx + qw) < w_q) ? (bx + qw) : (w_q - ONE_DIM);
    ey = ((by + qh) < h_q) ? (by + qh) : (h_q - ONE_DIM);
`else
    ex = bx + qw - ONE_DIM;
    ey = by + qh - ONE_DIM;
`endif
    ext_w    = ex - bx + ONE_DIM;
    ext_h    = ey - by + ONE_DIM;
    geom_bad = (qw == '0) || (qh == '0);
    // One-off product for the first row base; the scan itself only adds W.
    row_base = W_ADDR'(by) * W_ADDR'(w_q);
  end

  assign src_valid = (state_q == S_ISSUE);
  assign handshake = src_valid && src_ready;

  // Next-state, counters and address-walker control.
  always_comb begin
    state_d     = state_q;
    cuad_d      = cuad_q;
    w_d         = w_q;
    h_d         = h_q;
    quad_w_d    = quad_w_q;
    quad_h_d    = quad_h_q;
    iss_cnt_d   = iss_cnt_q;
    res_cnt_d   = res_cnt_q;
    gen_load    = 1'b0;
    gen_advance = 1'b0;

    // Results are counted whenever a job is live, including during ISSUE.
    if (res_valid && (state_q != S_IDLE) && (state_q != S_ERR)) begin
      res_cnt_d = res_cnt_q + ONE_ADDR;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cuad_d  = cuadrante;
          w_d     = W_DIM'(dimensiones[15:8]);
          h_d     = W_DIM'(dimensiones[7:0]);
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        quad_w_d = ext_w;
        quad_h_d = ext_h;
        if (geom_bad) begin
          state_d = S_ERR;
        end else begin
          gen_load = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          iss_cnt_d = iss_cnt_q + ONE_ADDR;
          if (gen_last) begin
            state_d = S_DRAIN;
          end else begin
            gen_advance = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Include this cycle's result so done follows the final one directly.
        if (res_cnt_d >= iss_cnt_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE, S_ERR: begin
        state_d   = S_IDLE;
        iss_cnt_d = '0;
        res_cnt_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, job parameters, extents and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cuad_q    <= '0;
      w_q       <= '0;
      h_q       <= '0;
      quad_w_q  <= '0;
      quad_h_q  <= '0;
      iss_cnt_q <= '0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cuad_q    <= cuad_d;
      w_q       <= w_d;
      h_q       <= h_d;
      quad_w_q  <= quad_w_d;
      quad_h_q  <= quad_h_d;
      iss_cnt_q <= iss_cnt_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  quad_addr_gen #(
    .W_DIM  (W_DIM),
    .W_ADDR (W_ADDR)
  ) u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .load          (gen_load),
    .advance       (gen_advance),
    .start_x       (bx),
    .end_x         (ex),
    .start_y       (by),
    .end_y         (ey),
    .width         (w_q),
    .row_base_init (row_base),
    .addr          (gen_addr),
    .last          (gen_last)
  );

  assign src_addr = gen_addr;
  assign quad_w   = quad_w_q;
  assign quad_h   = quad_h_q;
  assign busy     = (state_q == S_INIT) || (state_q == S_ISSUE) ||
                    (state_q == S_DRAIN) || (state_q == S_DONE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);

endmodule

// File: doc/quad_scan_ctrl.md
# quad_scan_ctrl

Sequencer for the interpolation pipeline. It takes a quadrant index and the image dimensions, then issues the row-major source-pixel addresses of that quadrant to the pipeline over a valid/ready handshake. It counts the result pixels the pipeline writes back and signals completion. It sits between the top-level control (quadrant select, start) and the pipeline's source-memory read port.

## Interface
- `W_DIM`, default 8: bit width of each image dimension.
- `W_ADDR`, default 16: bit width of source addresses and counters.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: begin a job; sampled only in IDLE.
- `cuadrante`  in  4: quadrant index. `row = cuadrante[3:2]`, `col = cuadrante[1:0]` of a 4x4 grid.
- `dimensiones`  in  16: image size. `[15:8]` is width W, `[7:0]` is height H. Sampled with `start`.
- `src_addr`  out  W_ADDR: source pixel address, `y*W + x`.
- `src_valid`  out  1: `src_addr` is valid.
- `src_ready`  in  1: pipeline accepts the address this cycle.
- `res_valid`  in  1: one result pixel written by the pipeline this cycle.
- `quad_w`, `quad_h`  out  W_DIM: registered scan extents of the current job.
- `busy`  out  1: high from the INIT state through the DONE state.
- `done`  out  1: one-cycle pulse at job completion.
- `err`  out  1: one-cycle pulse when the job is rejected.

## Operation
- States: IDLE, INIT, ISSUE, DRAIN, DONE, ERR.
- IDLE: on `start=1`, latch `cuadrante`, W and H, then go to INIT.
- INIT (1 cycle): compute the quadrant geometry and the first address.
  - `qw = W>>2`, `qh = H>>2`.
  - `bx = col*qw`, `by = row*qh`.
  - `ex = bx+qw-1`, `ey = by+qh-1`.
  - If `qw==0` or `qh==0`, go to ERR. Otherwise go to ISSUE.
  - Set `quad_w = ex-bx+1` and `quad_h = ey-by+1`.
- ISSUE: `src_valid=1`.
  - Addresses advance only on `src_valid && src_ready`: x increments; at `x==ex`, x wraps to `bx` and y increments.
  - The row base is accumulated by adding W per row. No multiplier is used in the scan.
  - Issued-address count increments on each handshake.
  - On the handshake of address `(ex,ey)`, go to DRAIN.
- DRAIN: wait until result count == issued count, then go to DONE.
- DONE: `done=1` for one cycle, then go to IDLE. Counters clear on entry to IDLE.
- ERR: `err=1` for one cycle, then go to IDLE. No address is issued.
- `res_valid` increments the result count in any state except IDLE and ERR. Results may arrive during ISSUE.
- `start` outside IDLE is ignored.

## Timing
- Reset values: state=IDLE; `src_addr=0`, `src_valid=0`, `quad_w=0`, `quad_h=0`, `busy=0`, `done=0`, `err=0`; all counters 0.
- Reset asserted mid-job: the next edge forces IDLE with all outputs at reset values. Pending results are discarded.
- Latency: `start` to first `src_valid` is 2 cycles (IDLE→INIT→ISSUE).
- With `src_ready` held high, one address is issued per cycle.
- `src_addr` holds stable while `src_valid && !src_ready`. `src_valid` never drops before the handshake.
- `src_valid` is 0 on the cycle after the last handshake.
- The final `res_valid` in DRAIN produces `done` on the next cycle.
- A `res_valid` coincident with the last address handshake is counted.
- `busy` drops in the same cycle the state returns to IDLE.

## Configuration
- `QUAD_BORDER_EN` defined: the scan extends one pixel right and one pixel down for bilinear neighbours.
  - `ex = min(bx+qw, W-1)`, `ey = min(by+qh, H-1)`.
  - `quad_w`/`quad_h` reflect the clamped extents.
- `QUAD_BORDER_EN` undefined: exact quadrant, `ex = bx+qw-1`, `ey = by+qh-1`.

## Structure
- Shared package `interp_pkg`:
  - state enum `scan_state_t`;
  - `W_DIM` and `W_ADDR` constants;
  - grid constant `GRID_LOG2 = 2`.
- One sub-module, `quad_addr_gen`: holds x, y and row-base registers, with `load`/`advance` inputs and a `last` output.
- The FSM, counters and pulses stay in `quad_scan_ctrl`.

## Test plan
- `dimensiones=16'h0808`, `cuadrante=5`, `src_ready=1`, border off:
  - addresses 18, 19, 26, 27 on consecutive cycles;
  - 4 `res_valid` pulses → `done` one cycle after the 4th;
  - `quad_w=quad_h=2`.
- Same job with `QUAD_BORDER_EN`:
  - addresses 18, 19, 20, 26, 27, 28, 34, 35, 36;
  - `cuadrante=15` gives 54, 55, 62, 63 (clamped), `quad_w=quad_h=2`.
- Backpressure: `src_ready` toggling 1,0,0,1 during the 8x8 job:
  - `src_addr` is held across the stall cycles;
  - no address is skipped or duplicated.
- `dimensiones=16'h0304`: `err` pulses 2 cycles after `start`, `src_valid` stays 0, `busy` returns to 0.
- Reset asserted after the 2nd handshake: next cycle `src_valid=0`, `busy=0`; a new `start` restarts from address 18.
- `start` pulsed during ISSUE is ignored; `res_valid` arriving during ISSUE is counted and `done` still follows the 4th result.
